mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access and MEM/WB pipeline stage of the MIPS pipeline. It consumes the EX/MEM pipeline register outputs and runs a request/acknowledge handshake to a variable-latency data memory. While an access is outstanding it stalls everything upstream. It registers the write-back results (RegWrite, destination, data) that feed the register file and the EX-stage forwarding muxes.

## Interface
- No parameters; data and address width fixed at 32, register index width fixed at 5.
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- RegWrite_in  in  1  EX/MEM RegWrite.
- memWrite_in  in  1  EX/MEM memWrite.
- memRead_in  in  1  EX/MEM memRead.
- memtoReg_in  in  1  EX/MEM memtoReg.
- writeDst_in  in  5  EX/MEM destination register index.
- ALU_in  in  32  EX/MEM ALU result; memory address for loads and stores.
- memWriteData_in  in  32  EX/MEM store data.
- mem_req  out  1  data-memory request, registered.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req=1.
- mem_addr  out  32  access address; valid while mem_req=1.
- mem_wdata  out  32  store data; valid while mem_req=1.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  32  load data; valid in the mem_ack cycle.
- stall  out  1  combinational; 1 = hold PC, IF/ID, ID/EX and EX/MEM.
- MemWBregWrite  out  1  registered write-back enable; also drives forwarding.
- MemWBRd  out  5  registered write-back destination.
- regFileWriteData  out  32  registered write-back data.

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- IDLE, (memRead_in | memWrite_in) = 1:
  - stall=1.
  - Latch mem_addr=ALU_in, mem_wdata=memWriteData_in, mem_we = memWrite_in & ~memRead_in. memRead has priority if both are set.
  - Set mem_req=1 and go to REQ.
- IDLE, no memory op: stall=0. MEM/WB loads RegWrite_in, writeDst_in, ALU_in.
- REQ:
  - stall=1. mem_req, mem_we, mem_addr, mem_wdata are held stable.
  - On mem_ack=1: capture mem_rdata into rdata_q, clear mem_req at the same edge, go to DONE.
- DONE:
  - stall=0 and mem_req=0. The EX/MEM inputs still present the same instruction; it is not relaunched.
  - MEM/WB loads RegWrite_in, writeDst_in, and write-back data = memtoReg_in ? rdata_q : ALU_in. Next state is IDLE.
- During stall=1 the MEM/WB registers hold their value. The repeated register-file write is idempotent, and forwarding to the held EX instruction stays valid.
- mem_ack outside REQ is ignored.
- MemWBregWrite is forced to 0 when writeDst_in=0 is loaded, so $zero is never written or forwarded.
- Reset, asynchronous and mid-access included:
  - State goes to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, MemWBregWrite, MemWBRd, regFileWriteData, rdata_q are all cleared to 0.
  - Any pending access is abandoned. A late mem_ack after reset is ignored.

## Timing
- Non-memory instruction: one cycle through the stage; results appear on the MEM/WB outputs after the next rising edge. No stall.
- Memory instruction arriving at cycle t, with mem_ack at cycle t+1+k (k ≥ 0):
  - stall=1 in cycles t … t+1+k.
  - DONE in cycle t+2+k; MEM/WB updated at the end of that cycle.
  - Total stall cycles = k+2.
- mem_req rises at the edge ending cycle t and falls at the edge of the ack cycle. There is never a back-to-back request without an intervening DONE.
- stall depends only on state and the current inputs (memRead_in, memWrite_in in IDLE). There is no combinational path from mem_ack to stall.

## Test plan
- Reset with rst=0 mid-REQ (mem_req=1) -> all outputs are 0 immediately; IDLE after release; an ack pulse 2 cycles later produces no MEM/WB change.
- R-type: RegWrite_in=1, writeDst_in=5, ALU_in=0x0000_1234, no memory op -> stall stays 0; next edge gives MemWBregWrite=1, MemWBRd=5, regFileWriteData=0x1234.
- Load:
  - Stimulus: memRead_in=1, memtoReg_in=1, writeDst_in=8, ALU_in=0x40, memory acks with mem_rdata=0xDEAD_BEEF after k=3.
  - Response: mem_req=1 with mem_addr=0x40, mem_we=0; stall=1 for 5 cycles; then MemWBRd=8, regFileWriteData=0xDEADBEEF.
- Store: memWrite_in=1, ALU_in=0x80, memWriteData_in=0xA5A5_A5A5, ack with k=0 -> mem_we=1, mem_wdata=0xA5A5A5A5; stall=1 for exactly 2 cycles; MemWBregWrite=0.
- Edge cases:
  - memRead_in=1 and memWrite_in=1 together -> mem_we=0, treated as a load.
  - R-type to writeDst_in=0 -> MemWBregWrite=0.
  - Spurious mem_ack in IDLE -> no state change.
- Back-to-back loads, each acked with k=1 -> two distinct request windows separated by a DONE cycle; no stall bubble lost; MEM/WB values held constant during each stall.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM stage with request/acknowledge data-memory handshake and MEM/WB pipeline register.
// Stalls upstream while an access is outstanding; write-back results are registered.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        memWrite_in,
  input  logic        memRead_in,
  input  logic        memtoReg_in,
  input  logic [4:0]  writeDst_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] memWriteData_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        MemWBregWrite,
  output logic [4:0]  MemWBRd,
  output logic [31:0] regFileWriteData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        launch_s;
  logic        ack_s;
  logic        wb_load_s;
  logic [31:0] rdata_q;
  logic [31:0] wb_data_s;

  // Next-state decode; stall never looks at mem_ack, only at state and the EX/MEM controls.
  always_comb begin
    state_next_s = state_r;
    stall        = 1'b0;
    launch_s     = 1'b0;
    ack_s        = 1'b0;
    wb_load_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (memRead_in | memWrite_in) begin
          stall        = 1'b1;
          launch_s     = 1'b1;
          state_next_s = REQ;
        end else begin
          wb_load_s    = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ack) begin
          ack_s        = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = REQ;
        end
      end
      DONE: begin
        wb_load_s    = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Write-back data select: loaded data only when completing a memory access.
  always_comb begin
    if ((state_r == DONE) && memtoReg_in) begin
      wb_data_s = rdata_q;
    end else begin
      wb_data_s = ALU_in;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Memory request interface; address/data/direction held for the whole REQ window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else if (launch_s) begin
      mem_req   <= 1'b1;
      mem_we    <= memWrite_in & ~memRead_in;
      mem_addr  <= ALU_in;
      mem_wdata <= memWriteData_in;
    end else if (ack_s) begin
      mem_req   <= 1'b0;
    end
  end

  // Load data capture on acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'd0;
    end else if (ack_s) begin
      rdata_q <= mem_rdata;
    end
  end

  // MEM/WB register; $zero is never marked as written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MemWBregWrite    <= 1'b0;
      MemWBRd          <= 5'd0;
      regFileWriteData <= 32'd0;
    end else if (wb_load_s) begin
      MemWBregWrite    <= RegWrite_in & (writeDst_in != 5'd0);
      MemWBRd          <= writeDst_in;
      regFileWriteData <= wb_data_s;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage with a hand-driven memory responder.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        RegWrite_in;
  logic        memWrite_in;
  logic        memRead_in;
  logic        memtoReg_in;
  logic [4:0]  writeDst_in;
  logic [31:0] ALU_in;
  logic [31:0] memWriteData_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        MemWBregWrite;
  logic [4:0]  MemWBRd;
  logic [31:0] regFileWriteData;

  int n_checks = 0;
  int n_pass   = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .memWrite_in(memWrite_in), .memRead_in(memRead_in),
    .memtoReg_in(memtoReg_in), .writeDst_in(writeDst_in), .ALU_in(ALU_in),
    .memWriteData_in(memWriteData_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .MemWBregWrite(MemWBregWrite), .MemWBRd(MemWBRd), .regFileWriteData(regFileWriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic rw, input logic mr, input logic mw, input logic m2r,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
    RegWrite_in     = rw;
    memRead_in      = mr;
    memWrite_in     = mw;
    memtoReg_in     = m2r;
    writeDst_in     = rd;
    ALU_in          = alu;
    memWriteData_in = wd;
    #1;
  endtask

  // Runs one memory instruction already presented on the inputs, acked after k wait cycles.
  task automatic do_mem(input string tag, input int k, input logic [31:0] rdata,
                        input logic exp_we, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic exp_rw, input logic [4:0] exp_rd, input logic [31:0] exp_wb);
    int          stalls;
    logic [31:0] held_data;
    logic [4:0]  held_rd;
    logic        held_rw;
    stalls    = 0;
    held_data = regFileWriteData;
    held_rd   = MemWBRd;
    held_rw   = MemWBregWrite;
    check({tag, "_stall_launch"}, {31'd0, stall}, 32'd1);
    if (stall) stalls++;
    tick();
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_we"}, {31'd0, mem_we}, {31'd0, exp_we});
    check({tag, "_addr"}, mem_addr, exp_addr);
    check({tag, "_wdata"}, mem_wdata, exp_wdata);
    for (int i = 0; i < k; i++) begin
      if (stall) stalls++;
      tick();
      check({tag, "_req_held"}, {31'd0, mem_req}, 32'd1);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    #1;
    if (stall) stalls++;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
    check({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_done_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_held_wb"}, {held_rw, held_rd, held_data[25:0]},
          {MemWBregWrite, MemWBRd, regFileWriteData[25:0]});
    check({tag, "_held_data"}, regFileWriteData, held_data);
    check({tag, "_stall_cycles"}, stalls, k + 2);
    tick();
    check({tag, "_wb_rw"}, {31'd0, MemWBregWrite}, {31'd0, exp_rw});
    check({tag, "_wb_rd"}, {27'd0, MemWBRd}, {27'd0, exp_rd});
    check({tag, "_wb_data"}, regFileWriteData, exp_wb);
  endtask

  initial begin
    rst       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    check("reset_req", {31'd0, mem_req}, 32'd0);
    check("reset_wb", {26'd0, MemWBregWrite, MemWBRd}, 32'd0);
    check("reset_data", regFileWriteData, 32'd0);
    #2 rst = 1'b1;
    tick();

    // R-type
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0);
    check("rtype_stall", {31'd0, stall}, 32'd0);
    tick();
    check("rtype_rw", {31'd0, MemWBregWrite}, 32'd1);
    check("rtype_rd", {27'd0, MemWBRd}, 32'd5);
    check("rtype_data", regFileWriteData, 32'h0000_1234);

    // Load, k=3
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 32'h40, 32'h0);
    do_mem("load", 3, 32'hDEAD_BEEF, 1'b0, 32'h40, 32'h0, 1'b1, 5'd8, 32'hDEAD_BEEF);

    // Store, k=0
    set_instr(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h80, 32'hA5A5_A5A5);
    do_mem("store", 0, 32'h0, 1'b1, 32'h80, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'h80);

    // Read and write together behave as a load
    set_instr(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'h44, 32'h5555_0000);
    do_mem("rdwr", 0, 32'h0BAD_F00D, 1'b0, 32'h44, 32'h5555_0000, 1'b1, 5'd9, 32'h0BAD_F00D);

    // R-type to $zero
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h777, 32'h0);
    tick();
    check("zero_rw", {31'd0, MemWBregWrite}, 32'd0);
    check("zero_data", regFileWriteData, 32'h777);

    // Spurious ack in IDLE
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h3333, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("spur_stall", {31'd0, stall}, 32'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    check("spur_req", {31'd0, mem_req}, 32'd0);
    check("spur_stall_after", {31'd0, stall}, 32'd0);
    check("spur_data", regFileWriteData, 32'h3333);

    // Back-to-back loads, k=1
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h100, 32'h0);
    do_mem("b2b1", 1, 32'h1111_1111, 1'b0, 32'h100, 32'h0, 1'b1, 5'd10, 32'h1111_1111);
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 32'h104, 32'h0);
    do_mem("b2b2", 1, 32'h2222_2222, 1'b0, 32'h104, 32'h0, 1'b1, 5'd11, 32'h2222_2222);

    // Reset in the middle of a request
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 32'h200, 32'h0);
    tick();
    check("mid_req_up", {31'd0, mem_req}, 32'd1);
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_bus", {mem_we, mem_addr[30:0]} | mem_wdata, 32'd0);
    check("mid_rst_wb", {26'd0, MemWBregWrite, MemWBRd} | regFileWriteData, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_CAFE;
    tick();
    mem_ack   = 1'b0;
    #1;
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_stall", {31'd0, stall}, 32'd0);
    tick();
    check("late_ack_wb", {26'd0, MemWBregWrite, MemWBRd} | regFileWriteData, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
